// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch-side PC generator, producer end of the IF pipeline register.
//
// Chooses the next fetch PC each cycle from, highest priority first:
//   1. commit-stage flush (overrides IF backpressure)
//   2. IF stall (hold; an execute redirect seen here is parked as pending)
//   3. execute-stage redirect
//   4. a redirect parked during an earlier stall
//   5. sequential increment by PC_STEP (wraps at 2^PC_WIDTH)
// Every redirect target is word aligned (bits [1:0] cleared) before use.
// A redirect shows up on pc one cycle after it is applied. if_flush is high
// only in the cycle the redirect is applied, so that the wrong-path IF entry
// being latched at the same edge is discarded.
//
// Fetch interface semantics: pc is a valid fetch address whenever pc_en=1.
// No ready signal comes back. Backpressure is signalled by if_stall, which
// holds pc. An entry latched while if_flush=1 must be dropped by the consumer.
//
// cpu_en=0 freezes all state, drops pc_en and ignores every redirect input.
//
// Ports:
//   clk             in   pipeline clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   cpu_en          in   global run enable
//   if_stall        in   IF/decode backpressure, hold pc
//   ex_redirect_en  in   execute-stage redirect valid
//   ex_redirect_pc  in   execute-stage redirect target
//   cmt_flush_en    in   commit-stage flush valid (highest priority)
//   cmt_flush_pc    in   commit-stage flush target
//   pc              out  registered fetch PC
//   pc_en           out  registered fetch request valid
//   if_flush        out  combinational discard strobe for the IF entry
//   pend_valid      out  registered, a stalled redirect is waiting
//
// Optional build macro PCGEN_MISALIGN_EN adds:
//   misalign_err    out  registered one-cycle pulse when a redirect target
//                        that is applied or captured has bits [1:0] != 0
//   misalign_addr   out  registered raw (unaligned) target of that redirect
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  PC_STEP      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_en,
  input  logic                if_stall,
  input  logic                ex_redirect_en,
  input  logic [PC_WIDTH-1:0] ex_redirect_pc,
  input  logic                cmt_flush_en,
  input  logic [PC_WIDTH-1:0] cmt_flush_pc,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_en,
  output logic                if_flush,
  output logic                pend_valid
`ifdef PCGEN_MISALIGN_EN
  ,
  output logic                misalign_err,
  output logic [PC_WIDTH-1:0] misalign_addr
`endif
);

  // Clears the two low address bits of a redirect target.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);

  // OFF        : out of reset, waiting for the first cpu_en
  // RUN        : fetching normally
  // STALL      : held by if_stall, nothing pending
  // STALL_PEND : held by if_stall with a redirect parked in pend_pc_q
  typedef enum logic [1:0] {
    ST_OFF        = 2'd0,
    ST_RUN        = 2'd1,
    ST_STALL      = 2'd2,
    ST_STALL_PEND = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q;
  logic [PC_WIDTH-1:0] pend_pc_d;
  logic                pend_valid_d;
  logic                pc_en_d;
  logic                flush_d;
  logic [PC_WIDTH-1:0] ex_tgt;
  logic [PC_WIDTH-1:0] cmt_tgt;

  assign ex_tgt  = ex_redirect_pc & ALIGN_MASK;
  assign cmt_tgt = cmt_flush_pc & ALIGN_MASK;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      pc         <= RESET_VECTOR;
      pc_en      <= 1'b0;
      pend_valid <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      pc_en      <= pc_en_d;
      pend_valid <= pend_valid_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-PC selection
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid;
    pc_en_d      = cpu_en;
    flush_d      = 1'b0;

    if (cpu_en) begin
      if (state_q == ST_OFF) begin
        // Entry cycle: start fetching at the reset vector without stepping.
        state_d = ST_RUN;
      end else if (cmt_flush_en) begin
        pc_d         = cmt_tgt;
        pend_valid_d = 1'b0;
        flush_d      = 1'b1;
        state_d      = ST_RUN;
      end else if (if_stall) begin
        if (ex_redirect_en) begin
          // Park the redirect; a later one in the same stall overwrites it.
          pend_pc_d    = ex_tgt;
          pend_valid_d = 1'b1;
          state_d      = ST_STALL_PEND;
        end else if (pend_valid) begin
          state_d = ST_STALL_PEND;
        end else begin
          state_d = ST_STALL;
        end
      end else if (ex_redirect_en) begin
        // A fresh redirect is younger than anything parked, so it wins.
        pc_d         = ex_tgt;
        pend_valid_d = 1'b0;
        flush_d      = 1'b1;
        state_d      = ST_RUN;
      end else if (pend_valid) begin
        pc_d         = pend_pc_q;
        pend_valid_d = 1'b0;
        flush_d      = 1'b1;
        state_d      = ST_RUN;
      end else begin
        pc_d    = pc + STEP;
        state_d = ST_RUN;
      end
    end
  end

  // Gating with rst_n keeps the strobe low while reset is held, independent
  // of whatever the redirect inputs are doing.
  assign if_flush = rst_n & flush_d;

`ifdef PCGEN_MISALIGN_EN
  // -------------------------------------------------------------------------
  // Misaligned redirect reporting. Only the redirect that is actually used
  // (applied or parked) this cycle is examined; a pending target was already
  // checked when it was parked.
  // -------------------------------------------------------------------------
  logic                mis_hit;
  logic [PC_WIDTH-1:0] mis_raw;

  always_comb begin
    mis_hit = 1'b0;
    mis_raw = cmt_flush_pc;
    if (cpu_en && (state_q != ST_OFF)) begin
      if (cmt_flush_en) begin
        mis_raw = cmt_flush_pc;
        mis_hit = |cmt_flush_pc[1:0];
      end else if (ex_redirect_en) begin
        mis_raw = ex_redirect_pc;
        mis_hit = |ex_redirect_pc[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_err <= mis_hit;
      if (mis_hit) begin
        misalign_addr <= mis_raw;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// Directed scenarios compare against fixed expected values; a randomized
// scenario compares against a behavioural model of the PC selection rules.
// Inputs change 1 ns after a rising edge; if_flush is sampled 2 ns after the
// edge, registered outputs 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_en;
  logic        if_stall;
  logic        ex_redirect_en;
  logic [31:0] ex_redirect_pc;
  logic        cmt_flush_en;
  logic [31:0] cmt_flush_pc;
  logic [31:0] pc;
  logic        pc_en;
  logic        if_flush;
  logic        pend_valid;
`ifdef PCGEN_MISALIGN_EN
  logic        misalign_err;
  logic [31:0] misalign_addr;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  always #5 clk = ~clk;

  pc_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_en         (cpu_en),
    .if_stall       (if_stall),
    .ex_redirect_en (ex_redirect_en),
    .ex_redirect_pc (ex_redirect_pc),
    .cmt_flush_en   (cmt_flush_en),
    .cmt_flush_pc   (cmt_flush_pc),
    .pc             (pc),
    .pc_en          (pc_en),
    .if_flush       (if_flush),
    .pend_valid     (pend_valid)
`ifdef PCGEN_MISALIGN_EN
    ,
    .misalign_err   (misalign_err),
    .misalign_addr  (misalign_addr)
`endif
  );

  // -------------------------------------------------------------------------
  // Reference model: fetch PC, fetch-valid, a parked redirect, and whether
  // the core has been started since reset.
  // -------------------------------------------------------------------------
  logic [31:0] m_pc;
  logic        m_pc_en;
  logic        m_pend_valid;
  logic [31:0] m_pend_pc;
  logic        m_started;
  logic        m_mis_err;
  logic [31:0] m_mis_addr;

  task automatic model_reset();
    m_pc         = 32'h0;
    m_pc_en      = 1'b0;
    m_pend_valid = 1'b0;
    m_pend_pc    = 32'h0;
    m_started    = 1'b0;
    m_mis_err    = 1'b0;
    m_mis_addr   = 32'h0;
  endtask

  task automatic model_note_target(input logic [31:0] t);
    if (t % 4 != 0) begin
      m_mis_err  = 1'b1;
      m_mis_addr = t;
    end
  endtask

  function automatic logic model_flush();
    if (!rst_n || !cpu_en || !m_started) return 1'b0;
    if (cmt_flush_en) return 1'b1;
    if (if_stall) return 1'b0;
    return ex_redirect_en || m_pend_valid;
  endfunction

  task automatic model_tick();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_mis_err = 1'b0;
    m_pc_en   = cpu_en;
    if (!cpu_en) return;
    if (!m_started) begin
      m_started = 1'b1;
      return;
    end
    if (cmt_flush_en) begin
      model_note_target(cmt_flush_pc);
      m_pc         = cmt_flush_pc - (cmt_flush_pc % 4);
      m_pend_valid = 1'b0;
    end else if (if_stall) begin
      if (ex_redirect_en) begin
        model_note_target(ex_redirect_pc);
        m_pend_pc    = ex_redirect_pc - (ex_redirect_pc % 4);
        m_pend_valid = 1'b1;
      end
    end else if (ex_redirect_en) begin
      model_note_target(ex_redirect_pc);
      m_pc         = ex_redirect_pc - (ex_redirect_pc % 4);
      m_pend_valid = 1'b0;
    end else if (m_pend_valid) begin
      m_pc         = m_pend_pc;
      m_pend_valid = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic clear_redirects();
    ex_redirect_en = 1'b0;
    cmt_flush_en   = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n          = 1'b0;
    cpu_en         = 1'b1;
    if_stall       = 1'b0;
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h40;
    cmt_flush_en   = 1'b1;
    cmt_flush_pc   = 32'h80;
    model_reset();
    repeat (2) tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
    checks++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", pend_valid); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", if_flush); end
`ifdef PCGEN_MISALIGN_EN
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_mis_err got=%b exp=0", misalign_err); end
    checks++; if (misalign_addr !== 32'h0) begin failures++; $display("FAIL reset_mis_addr got=%h exp=0", misalign_addr); end
`endif
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    clear_redirects();
    rst_n = 1'b1;
    exp_q = {32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 5; i++) begin
      #1;
      exp = exp_q.pop_front();
      checks++; if (pc !== exp) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp); end
      checks++; if (pc_en !== (i > 0)) begin failures++; $display("FAIL seq_pc_en[%0d] got=%b exp=%b", i, pc_en, (i > 0)); end
      checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL seq_flush[%0d] got=%b exp=0", i, if_flush); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_redirect();
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h100;
    #1;
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL redir_flush got=%b exp=1", if_flush); end
    tick();
    clear_redirects();
    #1;
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", pc); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL redir_flush_after got=%b exp=0", if_flush); end
    tick();
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL redir_pc_next got=%h exp=104", pc); end
  endtask

  task automatic test_stall_pending();
    cmt_flush_en = 1'b1;
    cmt_flush_pc = 32'h10;
    tick();
    clear_redirects();
    checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_setup_pc got=%h exp=10", pc); end
    if_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      ex_redirect_en = (c == 2);
      ex_redirect_pc = 32'h200;
      #1;
      checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL stall_flush[%0d] got=%b exp=0", c, if_flush); end
      tick();
      checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=10", c, pc); end
      checks++; if (pend_valid !== (c >= 2)) begin failures++; $display("FAIL stall_pend[%0d] got=%b exp=%b", c, pend_valid, (c >= 2)); end
    end
    if_stall = 1'b0;
    ex_redirect_en = 1'b0;
    #1;
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL unstall_flush got=%b exp=1", if_flush); end
    tick();
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL unstall_pc got=%h exp=200", pc); end
    checks++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL unstall_pend got=%b exp=0", pend_valid); end
    #1;
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL unstall_flush_after got=%b exp=0", if_flush); end
    tick();
    checks++; if (pc !== 32'h204) begin failures++; $display("FAIL unstall_pc_next got=%h exp=204", pc); end
  endtask

  task automatic test_flush_in_stall();
    if_stall       = 1'b1;
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h200;
    tick();
    clear_redirects();
    checks++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL fis_pend got=%b exp=1", pend_valid); end
    cmt_flush_en = 1'b1;
    cmt_flush_pc = 32'h400;
    #1;
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL fis_flush got=%b exp=1", if_flush); end
    tick();
    clear_redirects();
    checks++; if (pc !== 32'h400) begin failures++; $display("FAIL fis_pc got=%h exp=400", pc); end
    checks++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL fis_pend_clr got=%b exp=0", pend_valid); end
    if_stall = 1'b0;
    #1;
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL fis_flush_after got=%b exp=0", if_flush); end
    tick();
    checks++; if (pc !== 32'h404) begin failures++; $display("FAIL fis_pc_next got=%h exp=404", pc); end
  endtask

  task automatic test_priority();
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h300;
    cmt_flush_en   = 1'b1;
    cmt_flush_pc   = 32'h500;
    #1;
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL prio_flush got=%b exp=1", if_flush); end
    tick();
    clear_redirects();
    checks++; if (pc !== 32'h500) begin failures++; $display("FAIL prio_pc got=%h exp=500", pc); end
  endtask

  task automatic test_wrap();
    cmt_flush_en = 1'b1;
    cmt_flush_pc = 32'hFFFF_FFFC;
    tick();
    clear_redirects();
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=0", pc); end
  endtask

  task automatic test_cpu_en_off();
    if_stall       = 1'b1;
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h600;
    tick();
    checks++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL off_setup_pend got=%b exp=1", pend_valid); end
    if_stall       = 1'b0;
    cpu_en         = 1'b0;
    ex_redirect_pc = 32'h700;
    cmt_flush_en   = 1'b1;
    cmt_flush_pc   = 32'h800;
    #1;
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL off_flush got=%b exp=0", if_flush); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL off_pc[%0d] got=%h exp=0", i, pc); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL off_pc_en[%0d] got=%b exp=0", i, pc_en); end
      checks++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL off_pend[%0d] got=%b exp=1", i, pend_valid); end
    end
    cpu_en = 1'b1;
    clear_redirects();
    #1;
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL on_flush got=%b exp=1", if_flush); end
    tick();
    checks++; if (pc !== 32'h600) begin failures++; $display("FAIL on_pc got=%h exp=600", pc); end
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL on_pc_en got=%b exp=1", pc_en); end
  endtask

  task automatic test_misalign();
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h102;
    tick();
    clear_redirects();
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL mis_pc got=%h exp=100", pc); end
`ifdef PCGEN_MISALIGN_EN
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", misalign_err); end
    checks++; if (misalign_addr !== 32'h102) begin failures++; $display("FAIL mis_addr got=%h exp=102", misalign_addr); end
`endif
    tick();
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL mis_pc_next got=%h exp=104", pc); end
`ifdef PCGEN_MISALIGN_EN
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_err_pulse got=%b exp=0", misalign_err); end
`endif
  endtask

  task automatic test_reset_midop();
    if_stall       = 1'b1;
    ex_redirect_en = 1'b1;
    ex_redirect_pc = 32'h900;
    tick();
    ex_redirect_en = 1'b0;
    cmt_flush_en   = 1'b1;
    cmt_flush_pc   = 32'hA00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midrst_pc got=%h exp=0", pc); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL midrst_pc_en got=%b exp=0", pc_en); end
    checks++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL midrst_pend got=%b exp=0", pend_valid); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL midrst_flush got=%b exp=0", if_flush); end
    tick();
    clear_redirects();
    if_stall = 1'b0;
    rst_n    = 1'b1;
    exp_q = {32'h0, 32'h0, 32'h4};
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc !== exp_q[i]) begin failures++; $display("FAIL midrst_seq[%0d] got=%h exp=%h", i, pc, exp_q[i]); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    clear_redirects();
    if_stall = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cpu_en         = ($urandom_range(0, 9) != 0);
      if_stall       = ($urandom_range(0, 3) == 0);
      ex_redirect_en = ($urandom_range(0, 4) == 0);
      ex_redirect_pc = $urandom;
      cmt_flush_en   = ($urandom_range(0, 11) == 0);
      cmt_flush_pc   = $urandom;
      if ($urandom_range(0, 3) == 0) cmt_flush_pc[31:8] = '1;
      #1;
      checks++; if (if_flush !== model_flush()) begin failures++; $display("FAIL rnd_flush[%0d] got=%b exp=%b", i, if_flush, model_flush()); end
      tick();
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
      checks++; if (pc_en !== m_pc_en) begin failures++; $display("FAIL rnd_pc_en[%0d] got=%b exp=%b", i, pc_en, m_pc_en); end
      checks++; if (pend_valid !== m_pend_valid) begin failures++; $display("FAIL rnd_pend[%0d] got=%b exp=%b", i, pend_valid, m_pend_valid); end
`ifdef PCGEN_MISALIGN_EN
      checks++; if (misalign_err !== m_mis_err) begin failures++; $display("FAIL rnd_mis_err[%0d] got=%b exp=%b", i, misalign_err, m_mis_err); end
      checks++; if (misalign_addr !== m_mis_addr) begin failures++; $display("FAIL rnd_mis_addr[%0d] got=%h exp=%h", i, misalign_addr, m_mis_addr); end
`endif
    end
    clear_redirects();
  endtask

  // -------------------------------------------------------------------------
  // Sequence and final report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_pending();
    test_flush_in_stall();
    test_priority();
    test_wrap();
    test_cpu_en_off();
    test_misalign();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
